rng_aes_sequencer: RTL and testbench
====================================

# rng_aes_sequencer

Autonomous controller that sequences the AES core's register interface to produce whitened random words from the chaos RNG. It keys the AES core from RNG output, encrypts RNG blocks, and buffers the ciphertext in an output FIFO. It also arbitrates the AES register port between the sequencer and a host (Wishbone-side) requester. It sits between `rng_chaos_scroll`, the `aes` core and the user-project bus logic.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: output FIFO depth in 32-bit words. Must be a power of two, ≥4.
- `REKEY_BLOCKS`, default 16: number of blocks encrypted before a fresh key is loaded. 0 means key once per reset or host write.

Ports. Clock is `clk`; reset is `reset_n`, asynchronous, active-low.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous active-low reset.
- `en` in 1: run enable.
- `keylen` in 1: AES key length, 0 = 128-bit, 1 = 256-bit.
- `rng_word` in 32: free-running chaos RNG output.
- `aes_cs` out 1: AES core chip select.
- `aes_we` out 1: AES core write enable.
- `aes_address` out 8: AES core register address.
- `aes_write_data` out 32: AES core write data.
- `aes_read_data` in 32: AES core read data, combinational, valid in the same cycle as cs with we=0.
- `host_req` in 1: host requests the AES port.
- `host_we` in 1: host write enable.
- `host_addr` in 8: host register address.
- `host_wdata` in 32: host write data.
- `host_gnt` out 1: host currently owns the AES port.
- `host_rdata` out 32: read data returned to the host.
- `out_data` out 32: FIFO head word.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer pops the FIFO head.
- `busy` out 1: sequencer is in any state other than IDLE or HOST.
- `block_count` out 16: total blocks completed, wraps at 0xFFFF→0.

## Operation

AES register map:
- CTRL 0x08: bit0 init, bit1 next.
- STATUS 0x09: bit0 ready, bit1 valid.
- CONFIG 0x0A: bit0 encdec, bit1 keylen.
- KEY0–7: 0x10–0x17.
- BLOCK0–3: 0x20–0x23.
- RESULT0–3: 0x30–0x33.

States: IDLE, HOST, KEY_WR, CFG_WR, INIT, WAIT_INIT, BLK_WR, NEXT, WAIT_NEXT, RES_RD.

Transitions:
- IDLE → HOST when `host_req` is high. Host has priority over starting a new block.
- IDLE → KEY_WR when `en` = 1, `rekey_pend` = 1, and FIFO free ≥4.
- IDLE → BLK_WR when `en` = 1, `rekey_pend` = 0, and FIFO free ≥4.
- HOST: `host_gnt` = 1; `aes_*` pass through combinationally from `host_*`; `host_rdata` = `aes_read_data`. Any host write sets `rekey_pend`. Returns to IDLE on the cycle `host_req` is low.
- KEY_WR: 8 write cycles, addresses 0x10..0x17, data = `rng_word` in each cycle. All 8 words are always written, regardless of `keylen`.
- CFG_WR: writes 0x0A with {30'b0, `keylen`, 1'b1} (encrypt).
- INIT: writes 0x08 with 0x1. Then 1 settle cycle with `aes_cs` = 0.
- WAIT_INIT: reads 0x09 every cycle until bit0 = 1, then clears `rekey_pend` and goes to BLK_WR.
- BLK_WR: 4 writes, addresses 0x20..0x23, data = `rng_word`.
- NEXT: writes 0x08 with 0x2. Then 1 settle cycle.
- WAIT_NEXT: reads 0x09 until bit1 = 1.
- RES_RD: 4 reads, addresses 0x30..0x33. Each cycle pushes `aes_read_data` into the FIFO.
- After the 4th read: `block_count` += 1 and the rekey counter += 1. If `REKEY_BLOCKS` ≠ 0 and the counter reaches `REKEY_BLOCKS`, set `rekey_pend` and clear the counter. Go to IDLE.

Bus ownership and enable:
- `aes_cs` = 0 in IDLE and in settle cycles.
- The host is never granted mid-sequence: `host_gnt` = 0 outside HOST.
- `en` is sampled only in IDLE. Deasserting `en` mid-block completes the block.

FIFO:
- The 4-free-slot check is made before BLK_WR/KEY_WR, so no overflow is possible.
- Pop when `out_valid` && `out_ready`.
- Simultaneous push and pop keep occupancy unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.
- Free count = `FIFO_DEPTH` − occupancy. Occupancy uses a log2(`FIFO_DEPTH`)+1-bit counter.

## Timing

Reset (async assert, applies mid-operation too):
- State returns to IDLE and the FIFO empties.
- `rekey_pend` = 1; rekey counter = 0; `block_count` = 0.
- All outputs 0: `aes_cs`, `aes_we`, `aes_address`, `aes_write_data`, `host_gnt`, `host_rdata`, `out_valid`, `out_data`, `busy`.

Latency and FIFO timing:
- Keyed block (no rekey), IDLE to last push: 4 + 1 + 1 + P_next + 4 cycles, where P_next = number of WAIT_NEXT poll cycles (≥1).
- Rekey adds 8 + 1 + 1 + 1 + P_init cycles.
- A pushed word is visible on `out_valid`/`out_data` the next cycle.

Host arbitration:
- `host_gnt` rises 1 cycle after IDLE sees `host_req`.
- Host accesses are single-cycle while granted.
- `aes_*` outputs are registered in all sequencer states.

## Test plan

- **FIPS-197 C.1 vector.** `keylen` = 0, `rng_word` driven as a function of `aes_address`: 0x10–0x13 = 00010203, 04050607, 08090a0b, 0c0d0e0f; 0x20–0x23 = 00112233, 44556677, 8899aabb, ccddeeff. FIFO must yield 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; `block_count` = 1.
- **Rekey cadence.** `REKEY_BLOCKS` = 2, `out_ready` = 1, run 5 blocks. KEY_WR occurs before blocks 1, 3 and 5 only; `block_count` = 5.
- **Backpressure.** `FIFO_DEPTH` = 8, `out_ready` = 0. Exactly 2 blocks complete, the sequencer parks in IDLE, `out_valid` = 1 with 8 words held. Popping 4 words starts block 3 within 2 cycles.
- **Host arbitration.** Assert `host_req` during WAIT_NEXT. `host_gnt` stays 0 until RES_RD finishes, then is 1 one cycle after IDLE. A host write to 0x10 causes a KEY_WR before the next block.
- **Async reset mid-BLK_WR.** Pull `reset_n` low mid-BLK_WR. All outputs are 0 immediately (before the next clock edge), FIFO empty. After release, the sequence restarts with KEY_WR.
- **Enable drop.** Deassert `en` mid-KEY_WR. The current block completes (4 words pushed), then the sequencer stays in IDLE with `busy` = 0.

Source files
------------

// File: rtl/rng_aes_sequencer.sv
// Sequences the AES register port to whiten chaos-RNG output: key from RNG, encrypt
// RNG blocks, buffer ciphertext in a FIFO, and lend the port to a host between blocks.
module rng_aes_sequencer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int REKEY_BLOCKS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        keylen,
    input  logic [31:0] rng_word,
    output logic        aes_cs,
    output logic        aes_we,
    output logic [7:0]  aes_address,
    output logic [31:0] aes_write_data,
    input  logic [31:0] aes_read_data,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic [31:0] host_rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] block_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W     = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] BLOCK_WORDS = (AW+1)'(4);

    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_CONFIG  = 8'h0A;
    localparam logic [7:0] ADDR_KEY0    = 8'h10;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [7:0] ADDR_RESULT0 = 8'h30;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HOST, ST_KEY_WR, ST_CFG_WR, ST_INIT,
        ST_WAIT_INIT, ST_BLK_WR, ST_NEXT, ST_WAIT_NEXT, ST_RES_RD
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     cnt_inc_s;
    logic           aes_cs_q, aes_cs_d;
    logic           aes_we_q, aes_we_d;
    logic [7:0]     aes_addr_q, aes_addr_d;
    logic [31:0]    aes_wdata_q, aes_wdata_d;
    logic           use_rng_q, use_rng_d;
    logic           rekey_pend_q, rekey_pend_d;
    logic [15:0]    rekey_cnt_q, rekey_cnt_d;
    logic [15:0]    rekey_inc_s;
    logic [15:0]    block_count_q, block_count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    occ_q, occ_d;
    logic [AW:0]    free_s;
    logic           push_s;
    logic           pop_s;
    logic [31:0]    fifo_mem_q [FIFO_DEPTH];

    assign cnt_inc_s   = cnt_q + 3'd1;
    assign rekey_inc_s = rekey_cnt_q + 16'd1;
    assign free_s      = DEPTH_W - occ_q;

    // Sequencer next-state logic; aes_*_d describe the access of the following cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        aes_cs_d      = 1'b0;
        aes_we_d      = 1'b0;
        aes_addr_d    = 8'h00;
        aes_wdata_d   = 32'h0000_0000;
        use_rng_d     = 1'b0;
        rekey_pend_d  = rekey_pend_q;
        rekey_cnt_d   = rekey_cnt_q;
        block_count_d = block_count_q;
        push_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    state_d = ST_HOST;
                end else if (en && (free_s >= BLOCK_WORDS)) begin
                    cnt_d     = 3'd0;
                    aes_cs_d  = 1'b1;
                    aes_we_d  = 1'b1;
                    use_rng_d = 1'b1;
                    if (rekey_pend_q) begin
                        state_d    = ST_KEY_WR;
                        aes_addr_d = ADDR_KEY0;
                    end else begin
                        state_d    = ST_BLK_WR;
                        aes_addr_d = ADDR_BLOCK0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST: begin
                if (!host_req) begin
                    state_d = ST_IDLE;
                end else if (host_we) begin
                    rekey_pend_d = 1'b1;
                end else begin
                    state_d = ST_HOST;
                end
            end
            ST_KEY_WR: begin
                aes_cs_d = 1'b1;
                aes_we_d = 1'b1;
                if (cnt_q == 3'd7) begin
                    state_d     = ST_CFG_WR;
                    cnt_d       = 3'd0;
                    aes_addr_d  = ADDR_CONFIG;
                    aes_wdata_d = {30'b0, keylen, 1'b1};
                end else begin
                    cnt_d      = cnt_inc_s;
                    aes_addr_d = ADDR_KEY0 | {5'b0, cnt_inc_s};
                    use_rng_d  = 1'b1;
                end
            end
            ST_CFG_WR: begin
                state_d     = ST_INIT;
                cnt_d       = 3'd0;
                aes_cs_d    = 1'b1;
                aes_we_d    = 1'b1;
                aes_addr_d  = ADDR_CTRL;
                aes_wdata_d = 32'h0000_0001;
            end
            ST_INIT: begin
                // cnt 0 is the CTRL write, cnt 1 the idle settle cycle before polling
                if (cnt_q == 3'd0) begin
                    cnt_d = 3'd1;
                end else begin
                    state_d    = ST_WAIT_INIT;
                    cnt_d      = 3'd0;
                    aes_cs_d   = 1'b1;
                    aes_addr_d = ADDR_STATUS;
                end
            end
            ST_WAIT_INIT: begin
                if (aes_read_data[0]) begin
                    rekey_pend_d = 1'b0;
                    state_d      = ST_BLK_WR;
                    cnt_d        = 3'd0;
                    aes_cs_d     = 1'b1;
                    aes_we_d     = 1'b1;
                    aes_addr_d   = ADDR_BLOCK0;
                    use_rng_d    = 1'b1;
                end else begin
                    aes_cs_d   = 1'b1;
                    aes_addr_d = ADDR_STATUS;
                end
            end
            ST_BLK_WR: begin
                aes_cs_d = 1'b1;
                aes_we_d = 1'b1;
                if (cnt_q == 3'd3) begin
                    state_d     = ST_NEXT;
                    cnt_d       = 3'd0;
                    aes_addr_d  = ADDR_CTRL;
                    aes_wdata_d = 32'h0000_0002;
                end else begin
                    cnt_d      = cnt_inc_s;
                    aes_addr_d = ADDR_BLOCK0 | {6'b0, cnt_inc_s[1:0]};
                    use_rng_d  = 1'b1;
                end
            end
            ST_NEXT: begin
                if (cnt_q == 3'd0) begin
                    cnt_d = 3'd1;
                end else begin
                    state_d    = ST_WAIT_NEXT;
                    cnt_d      = 3'd0;
                    aes_cs_d   = 1'b1;
                    aes_addr_d = ADDR_STATUS;
                end
            end
            ST_WAIT_NEXT: begin
                aes_cs_d = 1'b1;
                if (aes_read_data[1]) begin
                    state_d    = ST_RES_RD;
                    cnt_d      = 3'd0;
                    aes_addr_d = ADDR_RESULT0;
                end else begin
                    aes_addr_d = ADDR_STATUS;
                end
            end
            ST_RES_RD: begin
                push_s = 1'b1;
                if (cnt_q == 3'd3) begin
                    state_d       = ST_IDLE;
                    cnt_d         = 3'd0;
                    block_count_d = block_count_q + 16'd1;
                    if ((REKEY_BLOCKS != 0) && (rekey_inc_s == 16'(REKEY_BLOCKS))) begin
                        rekey_pend_d = 1'b1;
                        rekey_cnt_d  = 16'd0;
                    end else begin
                        rekey_cnt_d = rekey_inc_s;
                    end
                end else begin
                    cnt_d      = cnt_inc_s;
                    aes_cs_d   = 1'b1;
                    aes_addr_d = ADDR_RESULT0 | {6'b0, cnt_inc_s[1:0]};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // FIFO pointer and occupancy update; a push and a pop together leave occupancy alone.
    always_comb begin
        pop_s    = (occ_q != '0) && out_ready;
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State, bus-access and FIFO control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            aes_cs_q      <= 1'b0;
            aes_we_q      <= 1'b0;
            aes_addr_q    <= 8'h00;
            aes_wdata_q   <= 32'h0000_0000;
            use_rng_q     <= 1'b0;
            rekey_pend_q  <= 1'b1;
            rekey_cnt_q   <= 16'd0;
            block_count_q <= 16'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            aes_cs_q      <= aes_cs_d;
            aes_we_q      <= aes_we_d;
            aes_addr_q    <= aes_addr_d;
            aes_wdata_q   <= aes_wdata_d;
            use_rng_q     <= use_rng_d;
            rekey_pend_q  <= rekey_pend_d;
            rekey_cnt_q   <= rekey_cnt_d;
            block_count_q <= block_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= aes_read_data;
        end
    end

    // Key and block words carry the RNG value of the very cycle they are written.
    assign host_gnt       = (state_q == ST_HOST);
    assign aes_cs         = host_gnt ? host_req : aes_cs_q;
    assign aes_we         = host_gnt ? (host_req & host_we) : aes_we_q;
    assign aes_address    = host_gnt ? host_addr : aes_addr_q;
    assign aes_write_data = host_gnt ? host_wdata : (use_rng_q ? rng_word : aes_wdata_q);
    assign host_rdata     = host_gnt ? aes_read_data : 32'h0000_0000;
    assign out_valid      = (occ_q != '0);
    assign out_data       = out_valid ? fifo_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_HOST);
    assign block_count    = block_count_q;

endmodule

// File: tb/tb_rng_aes_sequencer.sv
// Directed bench for rng_aes_sequencer with a behavioural AES register-port stub.
module tb_rng_aes_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        keylen = 1'b0;
    logic [31:0] rng_word;
    logic        aes_cs, aes_we;
    logic [7:0]  aes_address;
    logic [31:0] aes_write_data;
    logic [31:0] aes_read_data;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = 8'h00;
    logic [31:0] host_wdata = 32'h0;
    logic        host_gnt;
    logic [31:0] host_rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] block_count;

    logic        fips_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rng_aes_sequencer #(.FIFO_DEPTH(8), .REKEY_BLOCKS(2)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .keylen(keylen), .rng_word(rng_word),
        .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
        .aes_write_data(aes_write_data), .aes_read_data(aes_read_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .block_count(block_count)
    );

    // RNG source: FIPS-197 C.1 words by address, otherwise address/block-tagged words.
    always_comb begin
        if (fips_mode) begin
            case (aes_address)
                8'h10:   rng_word = 32'h0001_0203;
                8'h11:   rng_word = 32'h0405_0607;
                8'h12:   rng_word = 32'h0809_0a0b;
                8'h13:   rng_word = 32'h0c0d_0e0f;
                8'h20:   rng_word = 32'h0011_2233;
                8'h21:   rng_word = 32'h4455_6677;
                8'h22:   rng_word = 32'h8899_aabb;
                8'h23:   rng_word = 32'hccdd_eeff;
                default: rng_word = 32'h0;
            endcase
        end else begin
            rng_word = {aes_address, 8'h5A, block_count};
        end
    end

    // AES stub: registers, init/next latency, C.1 ciphertext on a matching key/block.
    logic [31:0] key_r [8];
    logic [31:0] blk_r [4];
    logic [1:0]  cfg_r;
    logic        st_ready, st_valid, next_mode;
    logic [3:0]  timer;
    logic        fips_hit;
    logic [31:0] res_s [4];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) key_r[i] <= 32'h0;
            for (int i = 0; i < 4; i++) blk_r[i] <= 32'h0;
            cfg_r <= 2'b00; st_ready <= 1'b1; st_valid <= 1'b0;
            next_mode <= 1'b0; timer <= 4'd0;
        end else begin
            if (timer != 4'd0) begin
                timer <= timer - 4'd1;
                if (timer == 4'd1) begin
                    st_ready <= 1'b1;
                    if (next_mode) st_valid <= 1'b1;
                end
            end
            if (aes_cs && aes_we) begin
                if (aes_address[7:4] == 4'h1) key_r[aes_address[2:0]] <= aes_write_data;
                if (aes_address[7:4] == 4'h2) blk_r[aes_address[1:0]] <= aes_write_data;
                if (aes_address == 8'h0A) cfg_r <= aes_write_data[1:0];
                if (aes_address == 8'h08 && aes_write_data[0]) begin
                    st_ready <= 1'b0; timer <= 4'd3; next_mode <= 1'b0;
                end
                if (aes_address == 8'h08 && aes_write_data[1]) begin
                    st_ready <= 1'b0; st_valid <= 1'b0; timer <= 4'd4; next_mode <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        fips_hit = (key_r[0] == 32'h0001_0203) && (key_r[1] == 32'h0405_0607) &&
                   (key_r[2] == 32'h0809_0a0b) && (key_r[3] == 32'h0c0d_0e0f) &&
                   (blk_r[0] == 32'h0011_2233) && (blk_r[1] == 32'h4455_6677) &&
                   (blk_r[2] == 32'h8899_aabb) && (blk_r[3] == 32'hccdd_eeff);
        if (fips_hit) begin
            res_s[0] = 32'h69c4_e0d8; res_s[1] = 32'h6a7b_0430;
            res_s[2] = 32'hd8cd_b780; res_s[3] = 32'h70b4_c55a;
        end else begin
            for (int i = 0; i < 4; i++) res_s[i] = blk_r[i] ^ key_r[i];
        end
        aes_read_data = 32'h0;
        if (aes_cs && !aes_we) begin
            if (aes_address == 8'h09) aes_read_data = {30'h0, st_valid, st_ready};
            else if (aes_address[7:4] == 4'h3) aes_read_data = res_s[aes_address[1:0]];
        end
    end

    // Records which block index each sequencer key load precedes.
    logic [15:0] key_mask;
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) key_mask <= 16'h0;
        else if (aes_cs && aes_we && aes_address == 8'h10 && !host_gnt)
            key_mask[block_count[3:0]] <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 1'b0; out_ready = 1'b0; host_req = 1'b0; host_we = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                              input logic [31:0] m);
        int n = 0;
        while (!(aes_cs && aes_we && aes_address == a && ((aes_write_data & m) == d)) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_bc(input string tag, input logic [15:0] target);
        int n = 0;
        while (block_count != target && n < 600) begin
            @(negedge clk); n++;
        end
        if (n >= 600) check(tag, {16'h0, block_count}, {16'h0, target});
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) check(tag, 32'd0, 32'd1);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
        check(tag, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic gnt_seen;

        // Reset values
        @(negedge clk);
        check("rst_cs", {31'h0, aes_cs}, 32'd0);
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_gnt", {31'h0, host_gnt}, 32'd0);
        check("rst_bc", {16'h0, block_count}, 32'd0);

        // FIPS-197 C.1 single block
        fips_mode = 1'b1; keylen = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        wait_busy("fips_start");
        en = 1'b0;
        wait_bc("fips_done", 16'd1);
        check("fips_cfg", {30'h0, cfg_r}, 32'h1);
        check("fips_keys", {16'h0, key_mask}, 32'h1);
        pop_check("fips_w0", 32'h69c4_e0d8);
        pop_check("fips_w1", 32'h6a7b_0430);
        pop_check("fips_w2", 32'hd8cd_b780);
        pop_check("fips_w3", 32'h70b4_c55a);
        check("fips_empty", {31'h0, out_valid}, 32'd0);
        check("fips_bc", {16'h0, block_count}, 32'd1);
        fips_mode = 1'b0;

        // Rekey cadence: 5 blocks, keys before blocks 1, 3, 5
        do_reset();
        out_ready = 1'b1; en = 1'b1;
        wait_bc("cad_4", 16'd4);
        wait_busy("cad_start5");
        en = 1'b0;
        wait_bc("cad_5", 16'd5);
        repeat (10) @(negedge clk);
        check("cad_bc", {16'h0, block_count}, 32'd5);
        check("cad_keys", {16'h0, key_mask}, 32'h15);
        check("cad_busy", {31'h0, busy}, 32'd0);
        out_ready = 1'b0;

        // Backpressure: two blocks fill the FIFO, popping four restarts
        do_reset();
        en = 1'b1;
        repeat (200) @(negedge clk);
        check("bp_bc", {16'h0, block_count}, 32'd2);
        check("bp_busy", {31'h0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) pop_check("bp_b1", 32'h3000_0000);
        n = 0;
        while (!busy && n < 2) begin @(negedge clk); n++; end
        check("bp_restart", {31'h0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) pop_check("bp_b2", 32'h3000_0001);
        en = 1'b0;

        // Host arbitration during WAIT_NEXT
        do_reset();
        out_ready = 1'b1; en = 1'b1;
        wait_write("host_next", 8'h08, 32'h2, 32'hFFFF_FFFF);
        @(negedge clk); @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h09;
        gnt_seen = 1'b0; n = 0;
        while (busy && n < 50) begin
            if (host_gnt) gnt_seen = 1'b1;
            @(negedge clk); n++;
        end
        check("host_gnt_seq", {31'h0, gnt_seen}, 32'd0);
        check("host_gnt_idle", {31'h0, host_gnt}, 32'd0);
        check("host_bc", {16'h0, block_count}, 32'd1);
        @(negedge clk);
        check("host_gnt_on", {31'h0, host_gnt}, 32'd1);
        check("host_rd_addr", {24'h0, aes_address}, 32'h09);
        check("host_rdata", host_rdata, 32'h3);
        host_we = 1'b1; host_addr = 8'h10; host_wdata = 32'hDEAD_BEEF;
        #1;
        check("host_we", {31'h0, aes_we}, 32'd1);
        check("host_wdata", aes_write_data, 32'hDEAD_BEEF);
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        check("host_gnt_off", {31'h0, host_gnt}, 32'd0);
        wait_busy("host_blk2");
        en = 1'b0;
        wait_bc("host_bc2", 16'd2);
        check("host_keys", {16'h0, key_mask}, 32'h3);

        // Async reset in the middle of BLK_WR of block 2
        do_reset();
        en = 1'b1;
        wait_bc("ar_b1", 16'd1);
        wait_write("ar_blk", 8'h21, 32'h0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check("ar_cs", {31'h0, aes_cs}, 32'd0);
        check("ar_we", {31'h0, aes_we}, 32'd0);
        check("ar_addr", {24'h0, aes_address}, 32'd0);
        check("ar_wdata", aes_write_data, 32'd0);
        check("ar_valid", {31'h0, out_valid}, 32'd0);
        check("ar_data", out_data, 32'd0);
        check("ar_busy", {31'h0, busy}, 32'd0);
        check("ar_bc", {16'h0, block_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!aes_cs && n < 10) begin @(negedge clk); n++; end
        check("ar_rekey", {24'h0, aes_address}, 32'h10);

        // Enable dropped mid-KEY_WR: the block completes, then stays idle
        wait_write("en_key3", 8'h13, 32'h0, 32'h0);
        en = 1'b0;
        wait_bc("en_done", 16'd1);
        repeat (10) @(negedge clk);
        check("en_busy", {31'h0, busy}, 32'd0);
        check("en_bc", {16'h0, block_count}, 32'd1);
        for (int i = 0; i < 4; i++) pop_check("en_w", 32'h3000_0000);
        check("en_empty", {31'h0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
